// File: rtl/serv_mtimer_pkg.sv
// Shared constants for the serv_mtimer machine timer: register word map and reset values.
package serv_mtimer_pkg;

   localparam logic [2:0] MTIME_LO    = 3'd0;
   localparam logic [2:0] MTIME_HI    = 3'd1;
   localparam logic [2:0] MTIMECMP_LO = 3'd2;
   localparam logic [2:0] MTIMECMP_HI = 3'd3;
   localparam logic [2:0] PRESCALE    = 3'd4;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/serv_mtimer_if.sv
// Wishbone classic slave bus bundle for serv_mtimer (cyc and stb combined).
interface serv_mtimer_if;
   logic        i_wb_cyc;
   logic        i_wb_we;
   logic [2:0]  i_wb_adr;
   logic [31:0] i_wb_dat;
   logic [3:0]  i_wb_sel;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;

   modport slave (
      input  i_wb_cyc, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
      output o_wb_rdt, o_wb_ack
   );

   modport master (
      output i_wb_cyc, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
      input  o_wb_rdt, o_wb_ack
   );
endinterface

// File: rtl/serv_mtimer_prescaler.sv
// Tick prescaler for serv_mtimer: 16-bit down-counter, tick on zero, reload from prescale.
// Only instantiated when SERV_MTIMER_PRESCALER_EN is defined.
module serv_mtimer_prescaler #(
   parameter bit RST_REGS = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic [15:0] i_load_val,
   input  logic [15:0] i_prescale,
   output logic        o_tick
);

   logic [15:0] r_cnt;

   assign o_tick = (r_cnt == 16'd0);

   // A prescale write restarts the period from the freshly written value.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n && RST_REGS) begin
         r_cnt <= 16'd0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (o_tick) begin
         r_cnt <= i_prescale;
      end else begin
         r_cnt <= r_cnt - 16'd1;
      end
   end

endmodule

// File: rtl/serv_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a 32-bit Wishbone slave, level mtip on o_irq.
// Optional tick prescaler (word 4) enabled by defining SERV_MTIMER_PRESCALER_EN.
module serv_mtimer
   import serv_mtimer_pkg::*;
#(
   parameter RESET_STRATEGY = "MINI"
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   serv_mtimer_if.slave   wb,
   output logic           o_irq
);

   localparam bit RST_REGS = (RESET_STRATEGY != "NONE");

   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic        r_ack;
   logic [31:0] r_rdt;
   logic        r_irq;

   logic        w_acc;
   logic        w_wr;
   logic        w_rd;
   logic        w_tick;
   logic [63:0] w_mtime_inc;
   logic [63:0] w_mtime_nxt;
   logic [63:0] w_mtimecmp_nxt;
   logic [31:0] w_rdata;

   function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdat,
                                           input logic [3:0]  sel,
                                           input logic        en);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (en && sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
      end
      return res;
   endfunction

   // Accept only when no ack is outstanding, so a held cyc alternates ack cycles.
   assign w_acc = wb.i_wb_cyc & ~r_ack;
   assign w_wr  = w_acc & wb.i_wb_we;
   assign w_rd  = w_acc & ~wb.i_wb_we;

   assign w_mtime_inc = r_mtime + {63'd0, w_tick};

   assign w_mtime_nxt = {
      f_merge(w_mtime_inc[63:32], wb.i_wb_dat, wb.i_wb_sel, w_wr && (wb.i_wb_adr == MTIME_HI)),
      f_merge(w_mtime_inc[31:0],  wb.i_wb_dat, wb.i_wb_sel, w_wr && (wb.i_wb_adr == MTIME_LO))
   };

   assign w_mtimecmp_nxt = {
      f_merge(r_mtimecmp[63:32], wb.i_wb_dat, wb.i_wb_sel, w_wr && (wb.i_wb_adr == MTIMECMP_HI)),
      f_merge(r_mtimecmp[31:0],  wb.i_wb_dat, wb.i_wb_sel, w_wr && (wb.i_wb_adr == MTIMECMP_LO))
   };

`ifdef SERV_MTIMER_PRESCALER_EN
   logic [15:0] r_prescale;
   logic        w_prescale_wr;
   logic [15:0] w_prescale_nxt;

   assign w_prescale_wr  = w_wr && (wb.i_wb_adr == PRESCALE);
   assign w_prescale_nxt = {wb.i_wb_sel[1] ? wb.i_wb_dat[15:8] : r_prescale[15:8],
                            wb.i_wb_sel[0] ? wb.i_wb_dat[7:0]  : r_prescale[7:0]};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n && RST_REGS) begin
         r_prescale <= 16'd0;
      end else if (w_prescale_wr) begin
         r_prescale <= w_prescale_nxt;
      end
   end

   serv_mtimer_prescaler #(
      .RST_REGS   (RST_REGS)
   ) u_prescaler (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_prescale_wr),
      .i_load_val (w_prescale_nxt),
      .i_prescale (r_prescale),
      .o_tick     (w_tick)
   );
`else
   assign w_tick = 1'b1;
`endif

   always_comb begin
      w_rdata = 32'd0;
      case (wb.i_wb_adr)
         MTIME_LO:    w_rdata = r_mtime[31:0];
         MTIME_HI:    w_rdata = r_mtime[63:32];
         MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
         MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
`ifdef SERV_MTIMER_PRESCALER_EN
         PRESCALE:    w_rdata = {16'd0, r_prescale};
`endif
         default:     w_rdata = 32'd0;
      endcase
   end

   // Timer state may skip reset; bus and irq state always reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n && RST_REGS) begin
         r_mtime    <= 64'd0;
         r_mtimecmp <= MTIMECMP_RST;
      end else begin
         r_mtime    <= w_mtime_nxt;
         r_mtimecmp <= w_mtimecmp_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ack <= 1'b0;
         r_rdt <= 32'd0;
         r_irq <= 1'b0;
      end else begin
         r_ack <= w_acc;
         if (w_rd) r_rdt <= w_rdata;
         r_irq <= (r_mtime >= r_mtimecmp);
      end
   end

   assign wb.o_wb_ack = r_ack;
   assign wb.o_wb_rdt = r_rdt;
   assign o_irq       = r_irq;

endmodule
